// File: rtl/averaging_multichannel.sv
// Parallel per-channel windowed averager with its own clear/add/show sequencer.
// Optional round-half-up mean when AVERAGING_ROUNDING_EN is defined (truncating otherwise).
module averaging_multichannel #(
    parameter int unsigned channel_count     = 4,
    parameter int unsigned bitwidth_sample   = 12,
    parameter int unsigned log2_sample_count = 3
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic                                       sample_valid,
    input  logic [channel_count*bitwidth_sample-1:0]   sample_value,
    output logic                                       busy,
    output logic                                       mean_valid,
    output logic [channel_count*bitwidth_sample-1:0]   mean_value,
    output logic [log2_sample_count:0]                 sample_index
);

    localparam int unsigned CH     = channel_count;
    localparam int unsigned W      = bitwidth_sample;
    localparam int unsigned N      = log2_sample_count;
    localparam int unsigned bitwidth_accumulator = W + N;
    localparam int unsigned ACC_W  = bitwidth_accumulator;
    localparam int unsigned IDX_W  = N + 1;
    localparam int unsigned WINDOW = 1 << N;

    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(WINDOW - 1);

`ifdef AVERAGING_ROUNDING_EN
    localparam int unsigned     SUM_W = ACC_W + 1;
    localparam logic [SUM_W-1:0] ROUND = SUM_W'(WINDOW >> 1);
`endif

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ACCUMULATE = 2'd1;
    localparam logic [1:0] ST_SHOW       = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             clear_c;
    logic             accept_c;
    logic             publish_c;
    logic [ACC_W-1:0] acc [CH];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        clear_c    = 1'b0;
        accept_c   = 1'b0;
        publish_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear_c    = 1'b1;
                    state_next = ST_ACCUMULATE;
                end
            end
            ST_ACCUMULATE: begin
                // A start always wins over a coincident sample, which is dropped.
                if (start) begin
                    clear_c = 1'b1;
                end else if (sample_valid) begin
                    accept_c = 1'b1;
                    if (sample_index == LAST_INDEX) begin
                        state_next = ST_SHOW;
                    end
                end
            end
            ST_SHOW: begin
                publish_c = 1'b1;
                if (start) begin
                    clear_c    = 1'b1;
                    state_next = ST_ACCUMULATE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Accumulators, index, and published means
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CH; i++) begin
                acc[i] <= '0;
            end
            sample_index <= '0;
            mean_value   <= '0;
            mean_valid   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            busy       <= (state_next != ST_IDLE);
            mean_valid <= publish_c;
            if (clear_c) begin
                sample_index <= '0;
            end else if (accept_c) begin
                sample_index <= sample_index + IDX_W'(1);
            end
            for (int unsigned i = 0; i < CH; i++) begin
                if (publish_c) begin
`ifdef AVERAGING_ROUNDING_EN
                    mean_value[i*W +: W] <= W'((SUM_W'(acc[i]) + ROUND) >> N);
`else
                    mean_value[i*W +: W] <= W'(acc[i] >> N);
`endif
                end
                if (clear_c) begin
                    acc[i] <= '0;
                end else if (accept_c) begin
                    acc[i] <= acc[i] + ACC_W'(sample_value[i*W +: W]);
                end
            end
        end
    end

endmodule
